psk_mod_sps: RTL and testbench
==============================

Name: psk_mod_sps

Overview:
Parametrised successor to the fixed 1-bit-per-16-sample BPSK/QPSK modulator. It accepts AXIS words of BYTES*8 bits and serialises every symbol in the word, LSB first. Each symbol is held for SPS carrier samples, and the I/Q carrier is mixed with the symbol. The block sits between the TX data FIFO and the DUC/DAC path in the 16.384 MHz domain. A true valid/ready handshake with a one-word prefetch gives gap-free back-to-back words.

Parameters:
WIDTH, 12, signed sample width of carrier and outputs
BYTES, 1, AXIS word width in bytes (>=1)
SPS, 16, samples per symbol (>=2; need not be a power of two)

Ports:
clk_16M384  in  1  sample clock
rst_n_16M384  in  1  asynchronous active-low reset
s_tdata  in  BYTES*8  data word
s_tvalid  in  1  AXIS valid
s_tready  out  1  AXIS ready
s_tlast  in  1  last word of frame
s_tuser  in  1  1 = BPSK, 0 = QPSK (applies to whole word)
carrier_I  in  WIDTH  signed cos
carrier_Q  in  WIDTH  signed sin
out_I  out  WIDTH  signed modulated I
out_Q  out  WIDTH  signed modulated Q
out_vld  out  1  sample valid
out_last  out  1  last sample of frame
out_is_bpsk  out  1  mode of current symbol
out_bits  out  2  raw symbol bits {I,Q}; BPSK = {b,0}
out_sym_start  out  1  first sample of each symbol
out_clk_sym  out  1  symbol-rate clock: 1 for samples 0..SPS/2-1, else 0
underflow  out  1  one-cycle pulse: word exhausted without tlast and no next word

Behaviour:
- Reset is asynchronous and active-low; the clock is a single clock. While reset is asserted, every output is 0 (including s_tready), and FSM = IDLE, cnt = 0, prefetch empty.
- Prefetch register (PF): s_tready = ~pf_valid, registered. A handshake is s_tvalid & s_tready, and stores tdata/tlast/tuser into PF.
- Symbols per word: BPSK N = BYTES*8, symbol k = bit k; QPSK N = BYTES*4, symbol k: I = bit 2k+1, Q = bit 2k.
- FSM IDLE: cnt held at 0 and outputs idle (out_I/out_Q/out_vld/out_last/out_sym_start/out_clk_sym = 0). If pf_valid, move PF into the word register (WR), set sym index = 0, empty PF, and go to ACTIVE.
- FSM ACTIVE: cnt counts 0..SPS-1 and wraps.
  - At cnt = SPS-1 with index < N-1: index++.
  - At cnt = SPS-1 with index = N-1 and pf_valid: reload WR from PF; no gap, cnt wraps to 0.
  - At cnt = SPS-1 with index = N-1 and PF empty: go to IDLE. If the WR word lacked tlast, pulse underflow on the next cycle.
- A simultaneous handshake and PF->WR move in the same cycle is impossible, because s_tready = 0 while PF is full. PF refills one cycle after it is consumed.
- Latency: handshake at edge E0 in IDLE -> WR load at E1 -> first registered sample at E2 (out_vld = 1, out_sym_start = 1).
- Output register, updated every cycle in ACTIVE:
  - out_I = I ? carrier_I : neg(carrier_I).
  - out_Q = bpsk ? 0 : (Q ? carrier_Q : neg(carrier_Q)).
  - neg(x) saturates: neg(-2^(WIDTH-1)) = 2^(WIDTH-1)-1.
- out_last = 1 only on sample SPS-1 of symbol N-1 of a tlast word.
- out_is_bpsk and out_bits follow the current symbol; they are aligned with out_I/out_Q.
- Mode changes take effect only at a word boundary.

Optional Feature:
PSK_MOD_DIFF_ENC_EN:
- Defined: differential encoding. For each rail, transmitted bit = data bit XOR previous transmitted bit on that rail. The reference bits are 1 after reset, and are reset to 1 after an out_last sample or an underflow. out_bits still reports the raw data bits.
- Undefined: absolute mapping as above, and no reference-bit state exists.

Test Plan:
- Reset/idle: hold rst_n low 5 cycles mid-stream -> all outputs 0 immediately (async). After release, s_tready = 1 next edge and out_vld = 0.
- BPSK: 0xA5, tuser = 1, tlast = 1, carrier_I = 1000 -> out_vld high exactly 128 cycles starting 2 cycles after handshake. out_I per symbol is +1000,-1000,+1000,-1000,-1000,+1000,-1000,+1000. out_Q = 0. out_last only on sample 128. out_sym_start pulses 8 times.
- QPSK back-to-back: 0x1B then 0xE4 (tuser = 0, tlast on second), tvalid held -> 128 contiguous valid samples with no gap. out_bits sequence is 11,10,01,00,00,01,10,11. out_last on sample 128.
- Underflow: single QPSK 0x00 with tlast = 0 -> 64 valid samples, then out_vld = 0 and underflow = 1 for exactly 1 cycle. s_tready stays 1.
- Saturation: carrier_I = -2048, carrier_Q = -2048, QPSK bits 00 -> out_I = out_Q = 2047.
- Diff-enc (PSK_MOD_DIFF_ENC_EN): BPSK 0x00 then 0xFF, tlast on second -> 0x00 gives out_I = +carrier_I for all 8 symbols. 0xFF then alternates -, +, -, +, ... starting with -carrier_I.

Source files
------------

// File: rtl/psk_mod_sps_if.sv
// AXI-Stream style input bundle for psk_mod_sps: word data, frame end, and
// per-word mode (tuser = 1 selects BPSK, 0 selects QPSK).
interface psk_mod_sps_if #(
    parameter int unsigned BYTES = 1
) ();
    logic [BYTES*8-1:0] s_tdata;
    logic               s_tvalid;
    logic               s_tready;
    logic               s_tlast;
    logic               s_tuser;

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        output s_tuser,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        input  s_tuser,
        output s_tready
    );
endinterface

// File: rtl/psk_mod_sps.sv
// BPSK/QPSK modulator with configurable word width and samples per symbol.
// Words are serialised LSB first, each symbol held for SPS carrier samples.
// A one-word prefetch register keeps back-to-back words gap-free.
// Optional differential encoding: define PSK_MOD_DIFF_ENC_EN.
module psk_mod_sps #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned BYTES = 1,
    parameter int unsigned SPS   = 16
) (
    input  logic                    clk_16M384,
    input  logic                    rst_n_16M384,
    psk_mod_sps_if.slave            s,
    input  logic signed [WIDTH-1:0] carrier_I,
    input  logic signed [WIDTH-1:0] carrier_Q,
    output logic signed [WIDTH-1:0] out_I,
    output logic signed [WIDTH-1:0] out_Q,
    output logic                    out_vld,
    output logic                    out_last,
    output logic                    out_is_bpsk,
    output logic [1:0]              out_bits,
    output logic                    out_sym_start,
    output logic                    out_clk_sym,
    output logic                    underflow
);

    localparam int unsigned DW = BYTES * 8;
    localparam int unsigned IW = $clog2(DW);
    localparam int unsigned CW = $clog2(SPS);

    localparam logic [IW-1:0] LastBpsk = IW'(DW - 1);
    localparam logic [IW-1:0] LastQpsk = IW'(DW / 2 - 1);
    localparam logic [CW-1:0] CntMax   = CW'(SPS - 1);
    localparam logic [CW-1:0] CntHalf  = CW'(SPS / 2);

    localparam logic signed [WIDTH-1:0] SMin = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] SMax = {1'b0, {(WIDTH-1){1'b1}}};

    typedef enum logic [0:0] {StIdle, StActive} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   wr_data;
    logic            wr_last;
    logic            wr_bpsk;
    logic            pf_valid;
    logic [DW-1:0]   pf_data;
    logic            pf_last;
    logic            pf_user;
    logic            tready_q;
    logic            uf_pend;
`ifdef PSK_MOD_DIFF_ENC_EN
    logic            ref_i;
    logic            ref_q;
`endif

    logic            hs;
    logic            end_sym;
    logic            sym_last;
    logic            load_wr;
    logic            pf_valid_d;
    logic [DW-1:0]   qshift;
    logic            bit_i;
    logic            bit_q;
    logic            tx_i;
    logic            tx_q;
    logic signed [WIDTH-1:0] neg_i;
    logic signed [WIDTH-1:0] neg_q;
    logic signed [WIDTH-1:0] nxt_i;
    logic signed [WIDTH-1:0] nxt_q;

    assign s.s_tready = tready_q;

    // Symbol extraction, mapping with saturating negation, prefetch bookkeeping
    always_comb begin
        hs       = s.s_tvalid & tready_q;
        end_sym  = (cnt == CntMax);
        sym_last = (idx == (wr_bpsk ? LastBpsk : LastQpsk));
        load_wr  = pf_valid & ((state == StIdle) |
                              ((state == StActive) & end_sym & sym_last));
        // PF is never full when a handshake lands, so the two cases are exclusive
        pf_valid_d = hs ? 1'b1 : (load_wr ? 1'b0 : pf_valid);

        qshift = wr_data >> {idx, 1'b0};
        bit_i  = wr_bpsk ? wr_data[idx] : qshift[1];
        bit_q  = wr_bpsk ? 1'b0 : qshift[0];
`ifdef PSK_MOD_DIFF_ENC_EN
        tx_i = bit_i ^ ref_i;
        tx_q = bit_q ^ ref_q;
`else
        tx_i = bit_i;
        tx_q = bit_q;
`endif
        neg_i = (carrier_I == SMin) ? SMax : -carrier_I;
        neg_q = (carrier_Q == SMin) ? SMax : -carrier_Q;
        nxt_i = tx_i ? carrier_I : neg_i;
        nxt_q = wr_bpsk ? '0 : (tx_q ? carrier_Q : neg_q);
    end

    // Control FSM, prefetch/word registers and registered sample outputs
    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            state         <= StIdle;
            cnt           <= '0;
            idx           <= '0;
            wr_data       <= '0;
            wr_last       <= 1'b0;
            wr_bpsk       <= 1'b0;
            pf_valid      <= 1'b0;
            pf_data       <= '0;
            pf_last       <= 1'b0;
            pf_user       <= 1'b0;
            tready_q      <= 1'b0;
            uf_pend       <= 1'b0;
            out_I         <= '0;
            out_Q         <= '0;
            out_vld       <= 1'b0;
            out_last      <= 1'b0;
            out_is_bpsk   <= 1'b0;
            out_bits      <= 2'b00;
            out_sym_start <= 1'b0;
            out_clk_sym   <= 1'b0;
            underflow     <= 1'b0;
`ifdef PSK_MOD_DIFF_ENC_EN
            ref_i         <= 1'b1;
            ref_q         <= 1'b1;
`endif
        end else begin
            pf_valid  <= pf_valid_d;
            tready_q  <= ~pf_valid_d;
            underflow <= uf_pend;
            uf_pend   <= 1'b0;
            if (hs) begin
                pf_data <= s.s_tdata;
                pf_last <= s.s_tlast;
                pf_user <= s.s_tuser;
            end

            out_I         <= '0;
            out_Q         <= '0;
            out_vld       <= 1'b0;
            out_last      <= 1'b0;
            out_is_bpsk   <= 1'b0;
            out_bits      <= 2'b00;
            out_sym_start <= 1'b0;
            out_clk_sym   <= 1'b0;

            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    if (pf_valid) begin
                        wr_data <= pf_data;
                        wr_last <= pf_last;
                        wr_bpsk <= pf_user;
                        idx     <= '0;
                        state   <= StActive;
                    end
                end
                StActive: begin
                    out_I         <= nxt_i;
                    out_Q         <= nxt_q;
                    out_vld       <= 1'b1;
                    out_last      <= wr_last & sym_last & end_sym;
                    out_is_bpsk   <= wr_bpsk;
                    out_bits      <= {bit_i, bit_q};
                    out_sym_start <= (cnt == '0);
                    out_clk_sym   <= (cnt < CntHalf);
                    if (end_sym) begin
                        cnt <= '0;
                        if (!sym_last) begin
                            idx <= idx + 1'b1;
                        end else if (pf_valid) begin
                            wr_data <= pf_data;
                            wr_last <= pf_last;
                            wr_bpsk <= pf_user;
                            idx     <= '0;
                        end else begin
                            state   <= StIdle;
                            uf_pend <= ~wr_last;
                        end
`ifdef PSK_MOD_DIFF_ENC_EN
                        // Reference restarts after frame end or underflow
                        if (sym_last && (wr_last || !pf_valid)) begin
                            ref_i <= 1'b1;
                            ref_q <= 1'b1;
                        end else begin
                            ref_i <= tx_i;
                            if (!wr_bpsk) ref_q <= tx_q;
                        end
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_psk_mod_sps.sv
// Directed bench for psk_mod_sps (WIDTH=12, BYTES=1, SPS=16).
module tb_psk_mod_sps;

    localparam int SPS    = 16;
    localparam int MaxCyc = 300;

    logic clk_16M384 = 1'b0;
    logic rst_n_16M384 = 1'b0;

    logic signed [11:0] carrier_I, carrier_Q, out_I, out_Q;
    logic        out_vld, out_last, out_is_bpsk, out_sym_start, out_clk_sym, underflow;
    logic [1:0]  out_bits;

    psk_mod_sps_if #(.BYTES(1)) s_if ();

    psk_mod_sps #(.WIDTH(12), .BYTES(1), .SPS(SPS)) dut (
        .clk_16M384    (clk_16M384),
        .rst_n_16M384  (rst_n_16M384),
        .s             (s_if.slave),
        .carrier_I     (carrier_I),
        .carrier_Q     (carrier_Q),
        .out_I         (out_I),
        .out_Q         (out_Q),
        .out_vld       (out_vld),
        .out_last      (out_last),
        .out_is_bpsk   (out_is_bpsk),
        .out_bits      (out_bits),
        .out_sym_start (out_sym_start),
        .out_clk_sym   (out_clk_sym),
        .underflow     (underflow)
    );

    initial forever #5 clk_16M384 = ~clk_16M384;

    int n_vec = 0;
    int n_err = 0;

    logic signed [11:0] c_i [MaxCyc];
    logic signed [11:0] c_q [MaxCyc];
    logic [1:0] c_bits [MaxCyc];
    logic c_vld [MaxCyc];
    logic c_last [MaxCyc];
    logic c_ss [MaxCyc];
    logic c_cs [MaxCyc];
    logic c_bp [MaxCyc];
    logic c_uf [MaxCyc];
    logic c_rdy [MaxCyc];

    logic [7:0] w_data [2];
    logic       w_last [2];
    logic       w_user [2];
    int         w_n;
    int         hs_cyc [2];

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sneg(input int x);
        return (x == -2048) ? 2047 : -x;
    endfunction

    // Offer w_n words and record outputs after each of ncyc rising edges.
    // Must be entered just after a falling edge.
    task automatic run(input int ncyc);
        int   sent;
        logic acc;
        sent = 0;
        for (int c = 0; c < MaxCyc; c++) begin
            c_vld[c] = 1'b0; c_ss[c] = 1'b0; c_uf[c] = 1'b0; c_last[c] = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            if (sent < w_n) begin
                s_if.s_tvalid = 1'b1;
                s_if.s_tdata  = w_data[sent];
                s_if.s_tlast  = w_last[sent];
                s_if.s_tuser  = w_user[sent];
            end else begin
                s_if.s_tvalid = 1'b0;
            end
            acc = s_if.s_tvalid && s_if.s_tready;
            @(negedge clk_16M384);
            if (acc) begin
                hs_cyc[sent] = c;
                sent++;
            end
            c_i[c] = out_I;   c_q[c] = out_Q;   c_bits[c] = out_bits;
            c_vld[c] = out_vld; c_last[c] = out_last; c_ss[c] = out_sym_start;
            c_cs[c] = out_clk_sym; c_bp[c] = out_is_bpsk; c_uf[c] = underflow;
            c_rdy[c] = s_if.s_tready;
        end
        s_if.s_tvalid = 1'b0;
        chk("words_accepted", sent, w_n);
    endtask

    // Compare a captured burst of nsym symbols starting at cycle base.
    task automatic check_stream(input string tag, input int base, input int nsym,
                                input logic bpsk, input logic [15:0] tx_i,
                                input logic [15:0] tx_q, input logic [15:0] raw_i,
                                input logic [15:0] raw_q, input int ci, input int cq,
                                input logic lastflag);
        int nv, nss, k, ph, c;
        nv = 0; nss = 0;
        for (int j = 0; j < MaxCyc; j++) begin
            nv  += c_vld[j] ? 1 : 0;
            nss += c_ss[j] ? 1 : 0;
        end
        chk({tag, "_vld_count"}, nv, nsym * SPS);
        chk({tag, "_symstart_count"}, nss, nsym);
        chk({tag, "_vld_before"}, c_vld[base-1], 0);
        chk({tag, "_vld_after"}, c_vld[base+nsym*SPS], 0);
        for (int s = 0; s < nsym * SPS; s++) begin
            k = s / SPS; ph = s % SPS; c = base + s;
            chk($sformatf("%s_vld[%0d]", tag, s), c_vld[c], 1);
            chk($sformatf("%s_I[%0d]", tag, s), c_i[c], tx_i[k] ? ci : sneg(ci));
            chk($sformatf("%s_Q[%0d]", tag, s), c_q[c],
                bpsk ? 0 : (tx_q[k] ? cq : sneg(cq)));
            chk($sformatf("%s_bits[%0d]", tag, s), c_bits[c], {raw_i[k], raw_q[k]});
            chk($sformatf("%s_bpsk[%0d]", tag, s), c_bp[c], bpsk);
            chk($sformatf("%s_symstart[%0d]", tag, s), c_ss[c], ph == 0);
            chk($sformatf("%s_clksym[%0d]", tag, s), c_cs[c], ph < SPS / 2);
            chk($sformatf("%s_last[%0d]", tag, s), c_last[c],
                lastflag && (s == nsym * SPS - 1));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vld"}, out_vld, 0);
        chk({tag, "_I"}, out_I, 0);
        chk({tag, "_Q"}, out_Q, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_ss"}, out_sym_start, 0);
        chk({tag, "_cs"}, out_clk_sym, 0);
        chk({tag, "_bits"}, out_bits, 0);
        chk({tag, "_bpsk"}, out_is_bpsk, 0);
        chk({tag, "_uf"}, underflow, 0);
        chk({tag, "_tready"}, s_if.s_tready, 0);
    endtask

    initial begin
        s_if.s_tvalid = 1'b0;
        s_if.s_tdata  = 8'h00;
        s_if.s_tlast  = 1'b0;
        s_if.s_tuser  = 1'b0;
        carrier_I = 12'sd1000;
        carrier_Q = 12'sd500;

        // Power-on reset
        #23;
        chk_all_zero("por");
        @(negedge clk_16M384);
        rst_n_16M384 = 1'b1;
        @(negedge clk_16M384);
        chk("por_tready", s_if.s_tready, 1);
        chk("por_vld", out_vld, 0);

`ifndef PSK_MOD_DIFF_ENC_EN
        // BPSK 0xA5 single word
        w_n = 1; w_data[0] = 8'hA5; w_last[0] = 1'b1; w_user[0] = 1'b1;
        run(140);
        chk("bpsk_hs", hs_cyc[0], 0);
        check_stream("bpsk", hs_cyc[0] + 2, 8, 1'b1, 16'h00A5, 16'h0000,
                     16'h00A5, 16'h0000, 1000, 500, 1'b1);

        // QPSK back-to-back 0x1B, 0xE4
        w_n = 2;
        w_data[0] = 8'h1B; w_last[0] = 1'b0; w_user[0] = 1'b0;
        w_data[1] = 8'hE4; w_last[1] = 1'b1; w_user[1] = 1'b0;
        run(140);
        chk("qpsk_hs0", hs_cyc[0], 0);
        chk("qpsk_hs1", hs_cyc[1], 2);
        check_stream("qpsk", 2, 8, 1'b0, 16'h00C3, 16'h00A5,
                     16'h00C3, 16'h00A5, 1000, 500, 1'b1);

        // Underflow: lone QPSK word without tlast
        w_n = 1; w_data[0] = 8'h00; w_last[0] = 1'b0; w_user[0] = 1'b0;
        run(80);
        check_stream("uflow", 2, 4, 1'b0, 16'h0000, 16'h0000,
                     16'h0000, 16'h0000, 1000, 500, 1'b0);
        chk("uflow_pulse_pre", c_uf[65], 0);
        chk("uflow_pulse", c_uf[66], 1);
        chk("uflow_pulse_post", c_uf[67], 0);
        chk("uflow_tready_mid", c_rdy[40], 1);
        chk("uflow_tready_at", c_rdy[66], 1);
        chk("uflow_tready_post", c_rdy[67], 1);

        // Saturating negation of the most negative carrier
        carrier_I = -12'sd2048;
        carrier_Q = -12'sd2048;
        w_n = 1; w_data[0] = 8'h00; w_last[0] = 1'b1; w_user[0] = 1'b0;
        run(80);
        chk("sat_I", c_i[2], 2047);
        chk("sat_Q", c_q[2], 2047);
        check_stream("sat", 2, 4, 1'b0, 16'h0000, 16'h0000,
                     16'h0000, 16'h0000, -2048, -2048, 1'b1);
        carrier_I = 12'sd1000;
        carrier_Q = 12'sd500;
`else
        // Differential BPSK: 0x00 then 0xFF with tlast on the second word
        w_n = 2;
        w_data[0] = 8'h00; w_last[0] = 1'b0; w_user[0] = 1'b1;
        w_data[1] = 8'hFF; w_last[1] = 1'b1; w_user[1] = 1'b1;
        run(280);
        chk("diff_hs1", hs_cyc[1], 2);
        check_stream("diff", 2, 16, 1'b1, 16'hAAFF, 16'h0000,
                     16'hFF00, 16'h0000, 1000, 500, 1'b1);
`endif

        // Asynchronous reset in the middle of a burst
        @(negedge clk_16M384);
        s_if.s_tvalid = 1'b1; s_if.s_tdata = 8'hA5;
        s_if.s_tlast = 1'b1;  s_if.s_tuser = 1'b1;
        @(negedge clk_16M384);
        s_if.s_tvalid = 1'b0;
        repeat (20) @(negedge clk_16M384);
        chk("mid_active_vld", out_vld, 1);
        #2;
        rst_n_16M384 = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        repeat (5) @(negedge clk_16M384);
        chk_all_zero("mid_rst_hold");
        rst_n_16M384 = 1'b1;
        @(negedge clk_16M384);
        chk("mid_rel_tready", s_if.s_tready, 1);
        chk("mid_rel_vld", out_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
